dead_time_pwm: RTL and testbench
================================

Name: dead_time_pwm

Overview:
- Downstream consumer of the etch-a-sketch triangle wave generator.
- Compares the N-bit triangle value against a double-buffered duty word to form a center-aligned PWM.
- Drives a complementary output pair (hi/lo) with programmable dead time, so both outputs are never high in the same cycle.
- Feeds the motor/LED driver pins of the sketch axes.

Parameters:
- N, 8, width of the triangle input and the duty word
- DEADTIME, 4, clk cycles both outputs are held low between any hi/lo handover (0 allowed)
- DTW, 8, width of the dead-time counter; DEADTIME must be < 2**DTW

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- ena  input  1  triangle step strobe; same signal that enables the triangle generator
- tri_in  input  N  current triangle value (0 .. 2**N-1)
- duty  input  N  new duty value
- duty_wr  input  1  one-cycle strobe; writes duty into the shadow register
- duty_pending  output  1  high while the shadow holds a value not yet applied
- out_en  input  1  output enable; low forces both outputs low
- pwm_hi  output  1  high-side drive
- pwm_lo  output  1  low-side drive
- valley  output  1  one-cycle pulse when the active duty is reloaded

Behaviour:
Reset:
- rst low asynchronously clears: shadow=0, active=0, duty_pending=0, pwm_hi=0, pwm_lo=0, valley=0, FSM=IDLE, dead counter=0.
- Reset mid-operation: outputs drop to 0 immediately, with no dead-time sequence.
Duty path:
- duty_wr loads shadow on the next clk edge and sets duty_pending=1.
- Reload condition: a cycle with ena=1 and tri_in==0. On that edge active<=shadow, duty_pending<=0 (only if it was set), and valley=1 for exactly that next cycle.
- valley pulses on every reload-condition cycle, whether or not duty_pending was set.
- duty_wr in the same cycle as a reload: the new duty goes to shadow only. active takes the old shadow value; duty_pending stays 1.
- A second duty_wr before reload overwrites shadow (last write wins).
Compare:
- raw = (active > tri_in), combinational, unsigned N-bit.
- active=0 gives raw always 0. active=2**N-1 gives raw 1 except at the peak.
- raw ignores ena; only tri_in changes matter.
FSM states (enum), all transitions on posedge clk:
- IDLE: both outputs 0. If out_en=1, go to DEAD_TO_HI when raw=1, else DEAD_TO_LO, loading counter=DEADTIME.
- HI_ON: pwm_hi=1, pwm_lo=0. If raw=0, go to DEAD_TO_LO with counter=DEADTIME.
- LO_ON: pwm_lo=1, pwm_hi=0. If raw=1, go to DEAD_TO_HI.
- DEAD_TO_HI / DEAD_TO_LO: both outputs 0. Counter decrements each clk. When counter==0 (or DEADTIME=0 at entry), enter the target ON state on that edge.
- Abort: if raw reverts during DEAD_x, return directly to the opposite ON state. This is safe because the target side was never driven.
- out_en=0 in any state: go to IDLE on the next edge, with outputs low from that edge.
- With DEADTIME=0, DEAD states are skipped; the handover happens in one edge and the outputs are never both high.
- Outputs are registered (decoded from state_q).
Latency:
- raw change at cycle t: the off-going side drops at t+1; the on-going side rises at t+1+DEADTIME.
Invariant:
- pwm_hi & pwm_lo == 0 in every cycle, including reset release.

Decomposition:
- Package pwm_pkg holds the FSM state typedef {IDLE, HI_ON, LO_ON, DEAD_TO_HI, DEAD_TO_LO}.
- Sub-module dead_time_inserter(clk, rst, raw, out_en, pwm_hi, pwm_lo) holds the FSM and counter.
- Top level holds the shadow/active duty registers, compare, and valley logic.

Test Plan:
- Reset: hold rst=0 with raw stimulus active -> pwm_hi=pwm_lo=0, duty_pending=0. Release with out_en=1, tri_in=0, active=0 -> pwm_lo rises exactly 5 clk later (DEADTIME=4).
- Duty reload: duty_wr with duty=128 mid-ramp -> active unchanged and duty_pending=1 until ena with tri_in==0. Then valley pulses once, duty_pending=0, and over one period pwm_hi is high for tri_in<128.
- Dead time: with active=100, triangle crosses 100 -> pwm_hi drops the next cycle, both low for exactly 4 cycles, then pwm_lo high. Mirror check on the down-ramp.
- Abort: force raw 1->0->1 with a 2-cycle glitch during DEAD_TO_LO -> pwm_hi returns high with no pwm_lo pulse.
- Extremes and DEADTIME=0: duty=0 -> pwm_hi never high. duty=255 -> pwm_lo high only around tri_in=255. With DEADTIME=0 -> handover in one edge and the overlap assertion never fires.
- out_en and async reset: out_en drop while HI_ON -> both low the next edge. Async rst assertion between clock edges -> outputs drop before the next edge.

Source files
------------

// File: rtl/dead_time_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared types for the dead-time PWM block. Holds the state
//            encoding of the complementary-output dead-time inserter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    HI_ON      = 3'd1,
    LO_ON      = 3'd2,
    DEAD_TO_HI = 3'd3,
    DEAD_TO_LO = 3'd4
  } pwm_state_e;

endpackage
`default_nettype wire

// File: rtl/dead_time_pwm_if.sv
`default_nettype none
// ============================================================================
// Module   : dead_time_pwm_if
// Purpose  : Bundles the triangle/duty inputs and PWM outputs of the
//            dead-time PWM block.
// Signals  : ena, tri_in[N], duty[N], duty_wr, out_en  (towards the block)
//            duty_pending, pwm_hi, pwm_lo, valley      (from the block)
// Modports : slave  - the PWM block itself
//            master - whoever drives the triangle/duty side
// Revision : 1.0 - initial release
// ============================================================================
interface dead_time_pwm_if #(
  parameter int N = 8
);
  logic         ena;
  logic [N-1:0] tri_in;
  logic [N-1:0] duty;
  logic         duty_wr;
  logic         out_en;
  logic         duty_pending;
  logic         pwm_hi;
  logic         pwm_lo;
  logic         valley;

  modport slave (
    input  ena, tri_in, duty, duty_wr, out_en,
    output duty_pending, pwm_hi, pwm_lo, valley
  );

  modport master (
    output ena, tri_in, duty, duty_wr, out_en,
    input  duty_pending, pwm_hi, pwm_lo, valley
  );
endinterface
`default_nettype wire

// File: rtl/dead_time_pwm_inserter.sv
`default_nettype none
// ============================================================================
// Module   : dead_time_inserter
// Purpose  : Turns a raw PWM level into a complementary hi/lo pair with
//            DEADTIME cycles of both-low between handovers. Both outputs
//            are registered and can never be high together.
// Ports    : clk    - system clock
//            rst    - asynchronous active-low reset
//            raw    - requested level (1 = high side)
//            out_en - low forces both outputs low (via IDLE)
//            pwm_hi - high-side drive (registered)
//            pwm_lo - low-side drive (registered)
// Revision : 1.0 - initial release
// ============================================================================
module dead_time_inserter
  import pwm_pkg::*;
#(
  parameter int DEADTIME = 4,
  parameter int DTW      = 8   // DEADTIME must fit: DEADTIME < 2**DTW
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic out_en,
  output logic pwm_hi,
  output logic pwm_lo
);

  localparam logic [DTW-1:0] DT_LOAD = DTW'(DEADTIME);
  localparam logic [DTW-1:0] CNT_ONE = DTW'(1);
  localparam bit             NO_DEAD = (DEADTIME == 0);

  pwm_state_e     state_q, state_d;
  logic [DTW-1:0] cnt_q, cnt_d;
  logic           hi_q, hi_d;
  logic           lo_q, lo_d;

  // The counter is loaded with DEADTIME on entry to a DEAD state and the ON
  // state is entered on the edge where it steps from 1 to 0, so exactly
  // DEADTIME both-low cycles are produced.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!out_en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (NO_DEAD) begin
            state_d = raw ? HI_ON : LO_ON;
          end else begin
            state_d = raw ? DEAD_TO_HI : DEAD_TO_LO;
            cnt_d   = DT_LOAD;
          end
        end
        HI_ON: begin
          if (!raw) begin
            if (NO_DEAD) begin
              state_d = LO_ON;
            end else begin
              state_d = DEAD_TO_LO;
              cnt_d   = DT_LOAD;
            end
          end
        end
        LO_ON: begin
          if (raw) begin
            if (NO_DEAD) begin
              state_d = HI_ON;
            end else begin
              state_d = DEAD_TO_HI;
              cnt_d   = DT_LOAD;
            end
          end
        end
        DEAD_TO_HI: begin
          // Request reverted: the high side was never driven, so the low
          // side can be restored without a new dead band.
          if (!raw) begin
            state_d = LO_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q <= CNT_ONE) begin
              state_d = HI_ON;
              cnt_d   = '0;
            end
          end
        end
        DEAD_TO_LO: begin
          if (raw) begin
            state_d = HI_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q <= CNT_ONE) begin
              state_d = LO_ON;
              cnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    // Outputs are decoded from the next state and registered alongside it.
    hi_d = (state_d == HI_ON);
    lo_d = (state_d == LO_ON);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign pwm_hi = hi_q;
  assign pwm_lo = lo_q;

endmodule
`default_nettype wire

// File: rtl/dead_time_pwm.sv
`default_nettype none
// ============================================================================
// Module   : dead_time_pwm
// Purpose  : Center-aligned PWM from a triangle wave. A double-buffered duty
//            word is compared against the triangle; the result drives a
//            complementary hi/lo pair through a dead-time inserter.
// Ports    : clk - system clock
//            rst - asynchronous active-low reset
//            bus - dead_time_pwm_if.slave:
//                  ena, tri_in, duty, duty_wr, out_en  (in)
//                  duty_pending, pwm_hi, pwm_lo, valley (out)
// Revision : 1.0 - initial release
// ============================================================================
module dead_time_pwm #(
  parameter int N        = 8,
  parameter int DEADTIME = 4,
  parameter int DTW      = 8
) (
  input  logic            clk,
  input  logic            rst,
  dead_time_pwm_if.slave  bus
);

  logic [N-1:0] shadow_q, shadow_d;
  logic [N-1:0] active_q, active_d;
  logic         pending_q, pending_d;
  logic         valley_q, valley_d;
  logic         reload;
  logic         raw;

  // Active duty only changes at the triangle valley so each PWM period is
  // symmetric.
  assign reload = bus.ena && (bus.tri_in == '0);

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    valley_d  = reload;
    if (reload) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    // A write colliding with a reload lands in the shadow only and stays
    // pending for the next valley.
    if (bus.duty_wr) begin
      shadow_d  = bus.duty;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      valley_q  <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      valley_q  <= valley_d;
    end
  end

  assign raw              = (active_q > bus.tri_in);
  assign bus.duty_pending = pending_q;
  assign bus.valley       = valley_q;

  dead_time_inserter #(
    .DEADTIME (DEADTIME),
    .DTW      (DTW)
  ) u_dti (
    .clk    (clk),
    .rst    (rst),
    .raw    (raw),
    .out_en (bus.out_en),
    .pwm_hi (bus.pwm_hi),
    .pwm_lo (bus.pwm_lo)
  );

endmodule
`default_nettype wire

// File: tb/tb_dead_time_pwm.sv
`default_nettype none
// ============================================================================
// Module   : tb_dead_time_pwm
// Purpose  : Self-checking bench for dead_time_pwm. Two instances run side
//            by side on identical stimulus: DEADTIME=4 and DEADTIME=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dead_time_pwm;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic       duty_wr = 1'b0;
  logic       out_en = 1'b0;
  logic [7:0] tri_v = 8'd0;
  logic [7:0] duty = 8'd0;
  bit         dir_up = 1'b1;

  always #5 clk = ~clk;

  dead_time_pwm_if #(.N(N)) bus_a ();
  dead_time_pwm_if #(.N(N)) bus_b ();

  assign bus_a.ena = ena;  assign bus_a.tri_in = tri_v;  assign bus_a.duty = duty;
  assign bus_a.duty_wr = duty_wr;  assign bus_a.out_en = out_en;
  assign bus_b.ena = ena;  assign bus_b.tri_in = tri_v;  assign bus_b.duty = duty;
  assign bus_b.duty_wr = duty_wr;  assign bus_b.out_en = out_en;

  dead_time_pwm #(.N(N), .DEADTIME(4), .DTW(8)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  dead_time_pwm #(.N(N), .DEADTIME(0), .DTW(8)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Duty path: plain registers. Output pair: expressed through how long the
  // request has been stable, not through FSM states. A side is granted once
  // the request has held for DEADTIME+1 cycles; the side granted last (or,
  // straight out of idle, the side opposite the first request) may be
  // re-driven immediately because the other side was never turned on.
  logic [7:0] m_shadow, m_active;
  logic       m_pend, m_valley;
  logic       m_hi [2];
  logic       m_lo [2];
  logic       m_last_hi [2];
  logic       m_prev_raw [2];
  logic       m_enabled [2];
  int         m_run [2];
  int         m_dt [2];

  int hi_cnt_a, hi_cnt_b, lo_bad_a, lo_bad_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_shadow = '0; m_active = '0; m_pend = 1'b0; m_valley = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_hi[i] = 1'b0; m_lo[i] = 1'b0; m_last_hi[i] = 1'b0;
      m_prev_raw[i] = 1'b0; m_enabled[i] = 1'b0; m_run[i] = 0;
    end
  endtask

  task automatic dt_model(input int i, input logic raw);
    if (!out_en) begin
      m_hi[i] = 1'b0; m_lo[i] = 1'b0; m_enabled[i] = 1'b0; m_run[i] = 0;
    end else begin
      if (!m_enabled[i]) begin
        m_enabled[i] = 1'b1; m_last_hi[i] = !raw; m_run[i] = 1;
      end else if (raw == m_prev_raw[i]) begin
        if (m_run[i] < 1000) m_run[i]++;
      end else begin
        m_run[i] = 1;
      end
      m_prev_raw[i] = raw;
      if (raw == m_last_hi[i] || m_run[i] > m_dt[i]) begin
        m_hi[i] = raw; m_lo[i] = !raw; m_last_hi[i] = raw;
      end else begin
        m_hi[i] = 1'b0; m_lo[i] = 1'b0;
      end
    end
  endtask

  // Advance the model over the coming edge, take the edge, then compare.
  task automatic tick();
    logic raw, reload;
    if (!rst) begin
      model_reset();
    end else begin
      raw    = (m_active > tri_v);
      reload = ena && (tri_v == 8'd0);
      dt_model(0, raw);
      dt_model(1, raw);
      if (reload) begin m_active = m_shadow; m_pend = 1'b0; end
      m_valley = reload;
      if (duty_wr) begin m_shadow = duty; m_pend = 1'b1; end
    end
    @(posedge clk);
    #1;
    chk("hi_a", bus_a.pwm_hi, m_hi[0]);
    chk("lo_a", bus_a.pwm_lo, m_lo[0]);
    chk("hi_b", bus_b.pwm_hi, m_hi[1]);
    chk("lo_b", bus_b.pwm_lo, m_lo[1]);
    chk("overlap_a", bus_a.pwm_hi & bus_a.pwm_lo, 0);
    chk("overlap_b", bus_b.pwm_hi & bus_b.pwm_lo, 0);
    chk("valley_a", bus_a.valley, m_valley);
    chk("pending_a", bus_a.duty_pending, m_pend);
    chk("valley_b", bus_b.valley, m_valley);
    chk("pending_b", bus_b.duty_pending, m_pend);
  endtask

  task automatic step_tri();
    if (dir_up) begin
      if (tri_v == 8'd255) begin dir_up = 1'b0; tri_v = 8'd254; end
      else tri_v = tri_v + 8'd1;
    end else begin
      if (tri_v == 8'd0) begin dir_up = 1'b1; tri_v = 8'd1; end
      else tri_v = tri_v - 8'd1;
    end
  endtask

  // Free-running triangle with random ena; optional random duty writes and
  // one-cycle out_en drops.
  task automatic run_tri(input int cycles, input int wr_pct, input bit rand_oe);
    for (int c = 0; c < cycles; c++) begin
      ena    = ($urandom_range(0, 3) != 0);
      out_en = rand_oe ? ($urandom_range(0, 99) != 0) : 1'b1;
      if ($urandom_range(0, 99) < wr_pct) begin
        duty_wr = 1'b1;
        case ($urandom_range(0, 3))
          0: duty = 8'd0;
          1: duty = 8'd255;
          default: duty = 8'($urandom);
        endcase
      end
      tick();
      duty_wr = 1'b0;
      if (ena) step_tri();
      if (bus_a.pwm_hi) hi_cnt_a++;
      if (bus_b.pwm_hi) hi_cnt_b++;
      if (bus_a.pwm_lo && tri_v < 8'd250) lo_bad_a++;
      if (bus_b.pwm_lo && tri_v < 8'd250) lo_bad_b++;
    end
    ena = 1'b0;
  endtask

  // Write a duty word, then force a reload with a valley cycle.
  task automatic load_duty(input logic [7:0] v);
    ena = 1'b0; duty = v; duty_wr = 1'b1;
    tick();
    duty_wr = 1'b0;
    tri_v = 8'd0; dir_up = 1'b1; ena = 1'b1;
    tick();
    ena = 1'b0; tri_v = 8'd1;
  endtask

  initial begin
    int guard;
    m_dt[0] = 4;
    m_dt[1] = 0;
    model_reset();

    // Reset held while inputs toggle.
    rst = 1'b0; out_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tri_v = 8'($urandom); ena = 1'($urandom); duty = 8'($urandom); duty_wr = 1'($urandom);
      tick();
      chk("rst_hi", bus_a.pwm_hi, 0);
      chk("rst_pend", bus_a.duty_pending, 0);
    end

    // Release: pwm_lo must rise exactly five edges later.
    tri_v = 8'd0; ena = 1'b0; duty_wr = 1'b0; out_en = 1'b1;
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("rel_lo_a", bus_a.pwm_lo, (k == 5) ? 1 : 0);
      chk("rel_hi_a", bus_a.pwm_hi, 0);
    end

    // Duty write mid-ramp stays pending until the valley.
    tri_v = 8'd60; dir_up = 1'b1;
    duty = 8'd128; duty_wr = 1'b1;
    tick();
    duty_wr = 1'b0;
    chk("wr_pending", bus_a.duty_pending, 1);
    guard = 0;
    while (bus_a.valley !== 1'b1 && guard < 2000) begin
      run_tri(1, 0, 1'b0);
      guard++;
    end
    chk("reload_valley", bus_a.valley, 1);
    chk("reload_pend_clr", bus_a.duty_pending, 0);
    run_tri(1, 0, 1'b0);
    chk("valley_single", bus_a.valley, 0);
    run_tri(700, 0, 1'b0);

    // Dead time around a crossing at 100, both directions.
    load_duty(8'd100);
    tri_v = 8'd99;
    for (int k = 0; k < 8; k++) tick();
    chk("pre_cross_hi", bus_a.pwm_hi, 1);
    tri_v = 8'd100;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("dt_fall_hi", bus_a.pwm_hi, 0);
      chk("dt_fall_lo", bus_a.pwm_lo, (k == 5) ? 1 : 0);
    end
    tri_v = 8'd99;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("dt_rise_lo", bus_a.pwm_lo, 0);
      chk("dt_rise_hi", bus_a.pwm_hi, (k == 5) ? 1 : 0);
    end

    // Two-cycle glitch during DEAD_TO_LO returns straight to HI.
    tri_v = 8'd150;
    tick(); chk("abort_hi0", bus_a.pwm_hi, 0); chk("abort_lo0", bus_a.pwm_lo, 0);
    tick(); chk("abort_hi1", bus_a.pwm_hi, 0); chk("abort_lo1", bus_a.pwm_lo, 0);
    tri_v = 8'd50;
    tick(); chk("abort_hi2", bus_a.pwm_hi, 1); chk("abort_lo2", bus_a.pwm_lo, 0);
    tick(); chk("abort_hi3", bus_a.pwm_hi, 1);

    // out_en drop while HI_ON.
    out_en = 1'b0;
    tick();
    chk("oe_hi_a", bus_a.pwm_hi, 0);
    chk("oe_hi_b", bus_b.pwm_hi, 0);
    tick();
    out_en = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk("pre_async_hi", bus_a.pwm_hi, 1);

    // Asynchronous reset between edges.
    #3;
    rst = 1'b0;
    #1;
    chk("async_hi_a", bus_a.pwm_hi, 0);
    chk("async_hi_b", bus_b.pwm_hi, 0);
    chk("async_lo_a", bus_a.pwm_lo, 0);
    model_reset();
    tick();
    tick();
    rst = 1'b1;

    // Extremes.
    load_duty(8'd0);
    run_tri(2, 0, 1'b0);
    hi_cnt_a = 0; hi_cnt_b = 0;
    run_tri(800, 0, 1'b0);
    chk("duty0_hi_a", hi_cnt_a, 0);
    chk("duty0_hi_b", hi_cnt_b, 0);

    load_duty(8'd255);
    run_tri(2, 0, 1'b0);
    lo_bad_a = 0; lo_bad_b = 0;
    run_tri(800, 0, 1'b0);
    chk("duty255_lo_a", lo_bad_a, 0);
    chk("duty255_lo_b", lo_bad_b, 0);

    // Random duty writes and out_en drops over several periods.
    run_tri(2500, 3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
